divisor_segmentado_param: RTL

- Fully pipelined signed/unsigned integer divider; successor of the team's single-mode segmented divider.
- Generalised in width and in bits retired per stage; adds per-operation signed/unsigned mode, tag passthrough, global stall, and divide-by-zero and overflow flags.
- Accepts one operation per cycle and sits as an arithmetic coprocessor slice between issue logic and writeback.

---
 rtl/divisor_segmentado_param.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/divisor_segmentado_param.sv
// Fully pipelined signed/unsigned restoring divider retiring BITS_ETAPA quotient bits per stage.
// Optional macro DIVISOR_CONT_EN adds saturating Ops_cnt / Div0_cnt completion counters.
module divisor_segmentado_param #(
    parameter int TAMANYO    = 32,
    parameter int BITS_ETAPA = 1,
    parameter int TAG_W      = 4
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               Start,
    input  logic               Signo,
    input  logic [TAMANYO-1:0] Num,
    input  logic [TAMANYO-1:0] Den,
    input  logic [TAG_W-1:0]   Tag_in,
    input  logic               Stall,
    output logic [TAMANYO-1:0] Coc,
    output logic [TAMANYO-1:0] Res,
    output logic [TAG_W-1:0]   Tag_out,
    output logic               Done,
    output logic               Div0,
    output logic               Ovf,
    output logic               Busy
`ifdef DIVISOR_CONT_EN
    ,
    output logic [15:0]        Ops_cnt,
    output logic [15:0]        Div0_cnt
`endif
);

    localparam int S = TAMANYO / BITS_ETAPA;
    localparam logic [TAMANYO-1:0] MIN_VAL = {1'b1, {(TAMANYO-1){1'b0}}};

    // Index 0 is the input stage, 1..S are the iteration stages.
    logic [S:0]         valid_q, negNum_q, negDen_q, div0_q, ovf_q;
    logic [TAG_W-1:0]   tag_q [0:S];
    logic [TAMANYO-1:0] quo_q [0:S];
    logic [TAMANYO:0]   acc_q [0:S];
    logic [TAMANYO-1:0] mag_q [0:S];

    logic [TAMANYO-1:0] quo_d [1:S];
    logic [TAMANYO:0]   acc_d [1:S];

    logic               numNeg, denNeg;
    logic [TAMANYO-1:0] numMag, denMag;
    logic [TAMANYO-1:0] coc_d, res_d;

    logic [TAMANYO-1:0] coc_q, res_q;
    logic [TAG_W-1:0]   tagOut_q;
    logic               done_q, div0Out_q, ovfOut_q;

    assign numNeg = Signo & Num[TAMANYO-1];
    assign denNeg = Signo & Den[TAMANYO-1];
    assign numMag = numNeg ? -Num : Num;
    assign denMag = denNeg ? -Den : Den;

    // Restoring division; ACCU keeps an extra bit so the shifted-out MSB is never lost.
    always_comb begin : iterStages
        logic [TAMANYO:0]   acc;
        logic [TAMANYO-1:0] quo;
        acc = '0;
        quo = '0;
        for (int k = 1; k <= S; k++) begin
            acc = acc_q[k-1];
            quo = quo_q[k-1];
            for (int b = 0; b < BITS_ETAPA; b++) begin
                {acc, quo} = {acc[TAMANYO-1:0], quo, 1'b0};
                if (acc >= {1'b0, mag_q[k-1]}) begin
                    acc    = acc - {1'b0, mag_q[k-1]};
                    quo[0] = 1'b1;
                end
            end
            acc_d[k] = acc;
            quo_d[k] = quo;
        end
    end

    assign coc_d = (negNum_q[S] ^ negDen_q[S]) ? -quo_q[S] : quo_q[S];
    assign res_d = negNum_q[S] ? -acc_q[S][TAMANYO-1:0] : acc_q[S][TAMANYO-1:0];

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            valid_q   <= '0;
            negNum_q  <= '0;
            negDen_q  <= '0;
            div0_q    <= '0;
            ovf_q     <= '0;
            for (int k = 0; k <= S; k++) begin
                tag_q[k] <= '0;
                quo_q[k] <= '0;
                acc_q[k] <= '0;
                mag_q[k] <= '0;
            end
            coc_q     <= '0;
            res_q     <= '0;
            tagOut_q  <= '0;
            done_q    <= 1'b0;
            div0Out_q <= 1'b0;
            ovfOut_q  <= 1'b0;
        end else if (!Stall) begin
            valid_q  <= {valid_q[S-1:0], Start};
            negNum_q <= {negNum_q[S-1:0], numNeg};
            negDen_q <= {negDen_q[S-1:0], denNeg};
            div0_q   <= {div0_q[S-1:0], (Den == '0)};
            ovf_q    <= {ovf_q[S-1:0], (Signo && (Num == MIN_VAL) && (Den == '1))};
            tag_q[0] <= Tag_in;
            quo_q[0] <= numMag;
            acc_q[0] <= '0;
            mag_q[0] <= denMag;
            for (int k = 1; k <= S; k++) begin
                tag_q[k] <= tag_q[k-1];
                quo_q[k] <= quo_d[k];
                acc_q[k] <= acc_d[k];
                mag_q[k] <= mag_q[k-1];
            end
            coc_q     <= coc_d;
            res_q     <= res_d;
            tagOut_q  <= tag_q[S];
            done_q    <= valid_q[S];
            div0Out_q <= div0_q[S];
            ovfOut_q  <= ovf_q[S];
        end
    end

    assign Coc     = coc_q;
    assign Res     = res_q;
    assign Tag_out = tagOut_q;
    assign Done    = done_q;
    assign Div0    = div0Out_q;
    assign Ovf     = ovfOut_q;
    assign Busy    = (|valid_q) | done_q;

`ifdef DIVISOR_CONT_EN
    logic [15:0] opsCnt_q, div0Cnt_q;

    // A result is consumed only on a Done cycle that is not stalled.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            opsCnt_q  <= '0;
            div0Cnt_q <= '0;
        end else if (done_q && !Stall) begin
            if (opsCnt_q != 16'hFFFF)
                opsCnt_q <= opsCnt_q + 16'd1;
            if (div0Out_q && (div0Cnt_q != 16'hFFFF))
                div0Cnt_q <= div0Cnt_q + 16'd1;
        end
    end

    assign Ops_cnt  = opsCnt_q;
    assign Div0_cnt = div0Cnt_q;
`endif

endmodule
